modulo_pc_preempcao: RTL and testbench

Program-counter register stage sitting directly downstream of the base-offset stage. It registers the final next-instruction address into the PC that feeds instruction memory and back into the offset stage as pc_atual. It also implements the OS preemption quantum. A user-mode instruction counter forces a jump to the OS handler when it expires and saves the interrupted user address for the scheduler.

---
 rtl/modulo_pc_preempcao_pkg.sv | 16 +
 rtl/modulo_pc_preempcao_contador_quantum.sv | 40 ++++
 rtl/modulo_pc_preempcao.sv | 93 +++++++++
 tb/tb_modulo_pc_preempcao.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_pc_preempcao_pkg.sv
// Constants shared by the PC stage, the offset stage and the OS register-file logic:
// memory map of user/OS regions and the privilege-state encoding.
package modulo_pc_preempcao_pkg;

  localparam int unsigned ADDR_WIDTH_PADRAO        = 13;
  localparam int unsigned QUANTUM_WIDTH_PADRAO     = 16;
  localparam int unsigned USER_BASE_PADRAO         = 1000;
  localparam int unsigned ENDERECO_TRATADOR_PADRAO = 4;
  localparam int unsigned PC_RESET_PADRAO          = 0;

  typedef enum logic {
    KERNEL  = 1'b0,
    USUARIO = 1'b1
  } estado_t;

endpackage

// File: rtl/modulo_pc_preempcao_contador_quantum.sv
// Preemption quantum counter: load, saturating decrement while a user program
// advances, and an expiry flag for the advance that consumes the last unit.
module modulo_pc_preempcao_contador_quantum
  import modulo_pc_preempcao_pkg::*;
#(
  parameter int unsigned QUANTUM_WIDTH = QUANTUM_WIDTH_PADRAO
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     avanca,
  input  logic                     halt,
  input  logic                     carregar,
  input  logic [QUANTUM_WIDTH-1:0] valor,
  input  logic                     habilitada,
  input  logic                     em_usuario,
  output logic [QUANTUM_WIDTH-1:0] contador,
  output logic                     expira
);

  logic decrementa;

  // A load in the same cycle wins over both decrement and expiry.
  always_comb begin
    decrementa = avanca & em_usuario & habilitada & (contador != '0) & ~carregar;
    expira     = decrementa & (contador == QUANTUM_WIDTH'(1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador <= '0;
    end else if (!halt) begin
      if (carregar) begin
        contador <= valor;
      end else if (decrementa) begin
        contador <= contador - QUANTUM_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/modulo_pc_preempcao.sv
// Program counter register with kernel/user tracking and quantum-based preemption
// that redirects execution to the OS handler and saves the interrupted user address.
module modulo_pc_preempcao
  import modulo_pc_preempcao_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_PADRAO,
  parameter int unsigned QUANTUM_WIDTH     = QUANTUM_WIDTH_PADRAO,
  parameter int unsigned USER_BASE         = USER_BASE_PADRAO,
  parameter int unsigned ENDERECO_TRATADOR = ENDERECO_TRATADOR_PADRAO,
  parameter int unsigned PC_RESET          = PC_RESET_PADRAO
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_WIDTH-1:0]    endereco_proximo,
  input  logic                     habilita,
  input  logic                     halt,
  input  logic [QUANTUM_WIDTH-1:0] quantum_valor,
  input  logic                     quantum_carregar,
  input  logic                     preempcao_habilitada,
  output logic [ADDR_WIDTH-1:0]    pc_atual,
  output logic [ADDR_WIDTH-1:0]    pc_salvo,
  output logic                     modo_usuario,
  output logic                     preempcao,
  output logic [QUANTUM_WIDTH-1:0] contador
);

  localparam logic [ADDR_WIDTH-1:0] BASE_USUARIO = ADDR_WIDTH'(USER_BASE);
  localparam logic [ADDR_WIDTH-1:0] TRATADOR     = ADDR_WIDTH'(ENDERECO_TRATADOR);
  localparam logic [ADDR_WIDTH-1:0] PC_INICIAL   = ADDR_WIDTH'(PC_RESET);

  estado_t estado, estado_prox;
  logic    avanca, destino_usuario, expira, preempta;

  // Expiry on a jump that already leaves user mode is an ordinary exit, not a preemption.
  always_comb begin
    avanca          = habilita & ~halt;
    destino_usuario = (endereco_proximo >= BASE_USUARIO);
    preempta        = expira & destino_usuario;
  end

  modulo_pc_preempcao_contador_quantum #(
    .QUANTUM_WIDTH(QUANTUM_WIDTH)
  ) u_contador (
    .clock     (clock),
    .reset_n   (reset_n),
    .avanca    (avanca),
    .halt      (halt),
    .carregar  (quantum_carregar),
    .valor     (quantum_valor),
    .habilitada(preempcao_habilitada),
    .em_usuario(estado == USUARIO),
    .contador  (contador),
    .expira    (expira)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= KERNEL;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    if (preempta) begin
      estado_prox = KERNEL;
    end else if (avanca) begin
      estado_prox = destino_usuario ? USUARIO : KERNEL;
    end
  end

  always_comb begin
    modo_usuario = (estado == USUARIO);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_atual  <= PC_INICIAL;
      pc_salvo  <= '0;
      preempcao <= 1'b0;
    end else begin
      preempcao <= preempta;
      if (preempta) begin
        pc_atual <= TRATADOR;
        pc_salvo <= endereco_proximo;
      end else if (avanca) begin
        pc_atual <= endereco_proximo;
      end
    end
  end

endmodule

// File: tb/tb_modulo_pc_preempcao.sv
// Bench for modulo_pc_preempcao: directed scenarios plus randomized traffic
// compared against a behavioural model of the PC/quantum rules.
module tb_modulo_pc_preempcao;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] endereco_proximo = '0;
  logic        habilita = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] quantum_valor = '0;
  logic        quantum_carregar = 1'b0;
  logic        preempcao_habilitada = 1'b0;
  logic [12:0] pc_atual, pc_salvo;
  logic        modo_usuario, preempcao;
  logic [15:0] contador;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int unsigned m_pc, m_salvo, m_cnt;
  bit          m_user, m_pulse;

  modulo_pc_preempcao dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .endereco_proximo    (endereco_proximo),
    .habilita            (habilita),
    .halt                (halt),
    .quantum_valor       (quantum_valor),
    .quantum_carregar    (quantum_carregar),
    .preempcao_habilitada(preempcao_habilitada),
    .pc_atual            (pc_atual),
    .pc_salvo            (pc_salvo),
    .modo_usuario        (modo_usuario),
    .preempcao           (preempcao),
    .contador            (contador)
  );

  always #5 clock = ~clock;

  task automatic modelo_reset();
    m_pc = 0; m_salvo = 0; m_cnt = 0; m_user = 0; m_pulse = 0;
  endtask

  // Applies one cycle of the rules to the model, then clocks the DUT.
  task automatic ciclo(input int unsigned prox, input bit hab, input bit hlt,
                       input int unsigned qv, input bit qc, input bit ph);
    bit adv, vai_usuario, dec, pre;
    endereco_proximo = 13'(prox); habilita = hab; halt = hlt;
    quantum_valor = 16'(qv); quantum_carregar = qc; preempcao_habilitada = ph;
    adv         = hab && !hlt;
    vai_usuario = (prox >= 1000);
    dec         = adv && m_user && ph && (m_cnt != 0) && !qc;
    pre         = dec && (m_cnt == 1) && vai_usuario;
    m_pulse = pre;
    if (!hlt && qc) m_cnt = qv;
    else if (dec) m_cnt = m_cnt - 1;
    if (pre) begin
      m_salvo = prox; m_pc = 4; m_user = 0;
    end else if (adv) begin
      m_pc = prox; m_user = vai_usuario;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic aplica_reset();
    reset_n = 1'b0;
    endereco_proximo = '0; habilita = 0; halt = 0;
    quantum_valor = '0; quantum_carregar = 0; preempcao_habilitada = 0;
    modelo_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    aplica_reset();
    ciclo(1000, 1, 0, 0, 0, 0);
    ciclo(0, 0, 0, 3, 1, 1);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pc_atual !== 13'd0) begin failures++; $display("FAIL reset_pc: got=%0d want=0", pc_atual); end
    checks++;
    if (contador !== 16'd0) begin failures++; $display("FAIL reset_contador: got=%0d want=0", contador); end
    checks++;
    if (preempcao !== 1'b0) begin failures++; $display("FAIL reset_preempcao: got=%0b want=0", preempcao); end
    checks++;
    if (modo_usuario !== 1'b0) begin failures++; $display("FAIL reset_modo: got=%0b want=0", modo_usuario); end
    checks++;
    if (pc_salvo !== 13'd0) begin failures++; $display("FAIL reset_pc_salvo: got=%0d want=0", pc_salvo); end
    aplica_reset();
  endtask

  task automatic test_modo();
    aplica_reset();
    ciclo(1000, 1, 0, 0, 0, 0);
    checks++;
    if (pc_atual !== 13'd1000 || modo_usuario !== 1'b1) begin
      failures++; $display("FAIL modo_entrada: pc=%0d modo=%0b want pc=1000 modo=1", pc_atual, modo_usuario);
    end
    ciclo(10, 1, 0, 0, 0, 0);
    checks++;
    if (pc_atual !== 13'd10 || modo_usuario !== 1'b0) begin
      failures++; $display("FAIL modo_saida: pc=%0d modo=%0b want pc=10 modo=0", pc_atual, modo_usuario);
    end
  endtask

  task automatic test_preempcao();
    aplica_reset();
    ciclo(1000, 1, 0, 0, 0, 1);
    ciclo(0, 0, 0, 3, 1, 1);
    checks++;
    if (contador !== 16'd3) begin failures++; $display("FAIL preemp_carga: got=%0d want=3", contador); end
    ciclo(1000, 1, 0, 0, 0, 1);
    ciclo(1001, 1, 0, 0, 0, 1);
    checks++;
    if (contador !== 16'd1 || pc_atual !== 13'd1001 || preempcao !== 1'b0) begin
      failures++; $display("FAIL preemp_meio: cnt=%0d pc=%0d pulso=%0b want cnt=1 pc=1001 pulso=0", contador, pc_atual, preempcao);
    end
    ciclo(1002, 1, 0, 0, 0, 1);
    checks++;
    if (pc_atual !== 13'd4 || pc_salvo !== 13'd1002) begin
      failures++; $display("FAIL preemp_pc: pc=%0d salvo=%0d want pc=4 salvo=1002", pc_atual, pc_salvo);
    end
    checks++;
    if (preempcao !== 1'b1 || contador !== 16'd0 || modo_usuario !== 1'b0) begin
      failures++; $display("FAIL preemp_flags: pulso=%0b cnt=%0d modo=%0b want 1 0 0", preempcao, contador, modo_usuario);
    end
    ciclo(0, 0, 0, 0, 0, 1);
    checks++;
    if (preempcao !== 1'b0 || pc_atual !== 13'd4) begin
      failures++; $display("FAIL preemp_pulso_unico: pulso=%0b pc=%0d want pulso=0 pc=4", preempcao, pc_atual);
    end
  endtask

  task automatic test_stall_halt();
    aplica_reset();
    ciclo(1000, 1, 0, 0, 0, 1);
    ciclo(0, 0, 0, 2, 1, 1);
    for (int i = 0; i < 5; i++) begin
      ciclo(1500 + i, 0, 0, 0, 0, 1);
      checks++;
      if (pc_atual !== 13'd1000 || contador !== 16'd2 || preempcao !== 1'b0 || modo_usuario !== 1'b1) begin
        failures++; $display("FAIL stall_%0d: pc=%0d cnt=%0d pulso=%0b want pc=1000 cnt=2 pulso=0", i, pc_atual, contador, preempcao);
      end
    end
    for (int i = 0; i < 5; i++) begin
      ciclo(20 + i, 1, 1, 9, 1, 1);
      checks++;
      if (pc_atual !== 13'd1000 || contador !== 16'd2 || preempcao !== 1'b0 || modo_usuario !== 1'b1) begin
        failures++; $display("FAIL halt_%0d: pc=%0d cnt=%0d pulso=%0b want pc=1000 cnt=2 pulso=0", i, pc_atual, contador, preempcao);
      end
    end
  endtask

  task automatic test_carga_vs_expira();
    aplica_reset();
    ciclo(1000, 1, 0, 0, 0, 1);
    ciclo(0, 0, 0, 1, 1, 1);
    ciclo(1005, 1, 0, 5, 1, 1);
    checks++;
    if (contador !== 16'd5 || pc_atual !== 13'd1005 || preempcao !== 1'b0 || modo_usuario !== 1'b1) begin
      failures++; $display("FAIL carga_vs_expira: cnt=%0d pc=%0d pulso=%0b want cnt=5 pc=1005 pulso=0", contador, pc_atual, preempcao);
    end
  endtask

  task automatic test_syscall_expira();
    aplica_reset();
    ciclo(1000, 1, 0, 0, 0, 1);
    ciclo(0, 0, 0, 1, 1, 1);
    ciclo(20, 1, 0, 0, 0, 1);
    checks++;
    if (pc_atual !== 13'd20 || contador !== 16'd0 || preempcao !== 1'b0 || modo_usuario !== 1'b0) begin
      failures++; $display("FAIL syscall_expira: pc=%0d cnt=%0d pulso=%0b modo=%0b want 20 0 0 0", pc_atual, contador, preempcao, modo_usuario);
    end
    checks++;
    if (pc_salvo !== 13'd0) begin failures++; $display("FAIL syscall_salvo: got=%0d want=0", pc_salvo); end
  endtask

  task automatic test_aleatorio();
    int unsigned prox, qv;
    bit hab, hlt, qc, ph;
    aplica_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) aplica_reset();
      case ($urandom_range(0, 3))
        0:       prox = $urandom_range(995, 1004);
        1:       prox = $urandom_range(0, 999);
        default: prox = $urandom_range(1000, 8191);
      endcase
      hab = ($urandom_range(0, 9) < 8);
      hlt = ($urandom_range(0, 9) == 0);
      qc  = ($urandom_range(0, 9) == 0);
      ph  = ($urandom_range(0, 9) != 0);
      qv  = $urandom_range(0, 4);
      ciclo(prox, hab, hlt, qv, qc, ph);
      checks++;
      if (pc_atual !== 13'(m_pc) || pc_salvo !== 13'(m_salvo) || contador !== 16'(m_cnt) ||
          modo_usuario !== m_user || preempcao !== m_pulse) begin
        failures++;
        $display("FAIL aleatorio_%0d: pc=%0d salvo=%0d cnt=%0d modo=%0b pulso=%0b want pc=%0d salvo=%0d cnt=%0d modo=%0b pulso=%0b",
                 i, pc_atual, pc_salvo, contador, modo_usuario, preempcao, m_pc, m_salvo, m_cnt, m_user, m_pulse);
      end
    end
  endtask

  initial begin
    modelo_reset();
    #12;
    test_reset();
    test_modo();
    test_preempcao();
    test_stall_halt();
    test_carga_vs_expira();
    test_syscall_expira();
    test_aleatorio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
